// File: rtl/rom_dl_pkg.sv
// Shared types and constants for the ROM download router.
package rom_dl_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_e;

  localparam logic [1:0] ERR_SHORT = 2'b01;
  localparam logic [1:0] ERR_OVF   = 2'b10;
  localparam int         IDX_W     = 4;

  // log2 of bytes per output word; this is the byte-to-word address shift
  function automatic int word_shift(input int data_w);
    return $clog2(data_w / 8);
  endfunction
endpackage

// File: rtl/rom_region_decode.sv
// Maps an absolute ioctl byte address onto a region index and region-relative offset.
module rom_region_decode
  import rom_dl_pkg::*;
#(
  parameter int                NUM_REGIONS = 8,
  parameter int                ADDR_W      = 17,
  parameter logic [16*25-1:0]  REGION_BASE = {16{25'h0}},
  parameter logic [24:0]       TOTAL_SIZE  = 25'h1C320
) (
  input  logic [24:0]       addr_i,
  output logic              hit_o,
  output logic [IDX_W-1:0]  idx_o,
  output logic [ADDR_W-1:0] offset_o
);
  // Bases ascend, so the last match in the scan is the highest qualifying region.
  always_comb begin
    idx_o    = '0;
    offset_o = ADDR_W'(addr_i - REGION_BASE[24:0]);
    for (int i = 1; i < NUM_REGIONS; i++) begin
      if (addr_i >= REGION_BASE[i*25 +: 25]) begin
        idx_o    = IDX_W'(i);
        offset_o = ADDR_W'(addr_i - REGION_BASE[i*25 +: 25]);
      end
    end
    hit_o = (addr_i >= REGION_BASE[24:0]) && (addr_i < TOTAL_SIZE);
  end
endmodule

// File: rtl/rom_dl_router.sv
// Routes the hps_io ioctl byte stream into per-region ROM write ports, packs
// bytes into DATA_W words, captures DIP bytes and tracks load status.
module rom_dl_router
  import rom_dl_pkg::*;
#(
  parameter int               NUM_REGIONS = 8,
  parameter int               ADDR_W      = 17,
  parameter int               DATA_W      = 8,
  parameter logic [16*25-1:0] REGION_BASE = {16{25'h0}},
  parameter logic [24:0]      TOTAL_SIZE  = 25'h1C320,
  parameter logic [7:0]       ROM_INDEX   = 8'd0,
  parameter logic [7:0]       DIP_INDEX   = 8'd254,
  parameter int               DIP_BYTES   = 2
) (
  input  logic                   clk_sys,
  input  logic                   reset,
  input  logic                   ioctl_download,
  input  logic                   ioctl_wr,
  input  logic [24:0]            ioctl_addr,
  input  logic [7:0]             ioctl_dout,
  input  logic [7:0]             ioctl_index,
  output logic [NUM_REGIONS-1:0] rom_wr,
  output logic [ADDR_W-1:0]      rom_addr,
  output logic [DATA_W-1:0]      rom_data,
  output logic [8*DIP_BYTES-1:0] dip_sw,
  output logic                   load_done,
  output logic                   load_err,
  output logic [1:0]             err_code,
  output logic [24:0]            bytes_loaded
);
  localparam int SH = word_shift(DATA_W);

  state_e state_q, state_d;
  logic hit, is_rom, start, rom_byte, acc, ovf, fin;
  logic [IDX_W-1:0]  idx;
  logic [ADDR_W-1:0] off, waddr;

  logic                   out_vld;
  logic [IDX_W-1:0]       out_idx;
  logic [ADDR_W-1:0]      out_addr;
  logic [DATA_W-1:0]      out_data;
  logic [NUM_REGIONS-1:0] rom_wr_q, rom_wr_d;
  logic [ADDR_W-1:0]      rom_addr_q;
  logic [DATA_W-1:0]      rom_data_q;
  logic [8*DIP_BYTES-1:0] dip_q, dip_d;
  logic [24:0]            bytes_q, bytes_d;
  logic [1:0]             err_q, err_d;
  logic                   lerr_q, lerr_d, done_q, done_d;

  rom_region_decode #(
    .NUM_REGIONS (NUM_REGIONS),
    .ADDR_W      (ADDR_W),
    .REGION_BASE (REGION_BASE),
    .TOTAL_SIZE  (TOTAL_SIZE)
  ) u_dec (
    .addr_i   (ioctl_addr),
    .hit_o    (hit),
    .idx_o    (idx),
    .offset_o (off)
  );

  assign waddr    = off >> SH;
  assign is_rom   = (ioctl_index == ROM_INDEX);
  assign start    = ioctl_download && is_rom && (state_q != LOAD);
  assign rom_byte = (state_q == LOAD) && ioctl_wr && is_rom;
  assign acc      = rom_byte && hit;
  assign ovf      = rom_byte && !hit;
  assign fin      = (state_q == LOAD) && !ioctl_download;

  always_ff @(posedge clk_sys) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start) state_d = LOAD;
      LOAD:       if (!ioctl_download) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  // A byte arriving on the final LOAD cycle is counted before the length check.
  always_comb begin
    bytes_d = bytes_q;
    err_d   = err_q;
    lerr_d  = lerr_q;
    done_d  = done_q;
    if (start) begin
      bytes_d = '0;
      err_d   = '0;
      lerr_d  = 1'b0;
      done_d  = 1'b0;
    end else begin
      if (acc && bytes_q != '1) bytes_d = bytes_q + 25'd1;
      if (ovf) err_d = err_d | ERR_OVF;
      if (fin) begin
        if (bytes_d < TOTAL_SIZE) err_d = err_d | ERR_SHORT;
        done_d = (err_d == 2'b00);
      end
      lerr_d = lerr_q | (err_d != 2'b00);
    end
  end

  always_comb begin
    dip_d = dip_q;
    for (int k = 0; k < DIP_BYTES; k++)
      if (ioctl_wr && ioctl_index == DIP_INDEX && ioctl_addr == 25'(k))
        dip_d[8*k +: 8] = ioctl_dout;
  end

  if (DATA_W == 16) begin : g_pack16
    logic              lat_vld_q, lat_vld_d, pnd_vld_q, pnd_vld_d;
    logic [7:0]        lat_byte_q, lat_byte_d;
    logic [IDX_W-1:0]  lat_idx_q, lat_idx_d, pnd_idx_q, pnd_idx_d;
    logic [ADDR_W-1:0] lat_addr_q, lat_addr_d, pnd_addr_q, pnd_addr_d;
    logic [15:0]       pnd_data_q, pnd_data_d, a_data, b_data;
    logic              same, a_vld, b_vld;

    // A = flush of a stale latched low byte, B = word completed by this byte.
    always_comb begin
      same       = lat_vld_q && lat_idx_q == idx && lat_addr_q == waddr;
      a_vld      = 1'b0;
      b_vld      = 1'b0;
      a_data     = {8'h00, lat_byte_q};
      b_data     = {ioctl_dout, 8'h00};
      lat_vld_d  = lat_vld_q;
      lat_byte_d = lat_byte_q;
      lat_idx_d  = lat_idx_q;
      lat_addr_d = lat_addr_q;
      if (acc) begin
        a_vld = lat_vld_q && !same;
        if (off[0]) begin
          b_vld     = 1'b1;
          b_data    = {ioctl_dout, same ? lat_byte_q : 8'h00};
          lat_vld_d = 1'b0;
        end else if (fin) begin
          b_vld     = 1'b1;
          b_data    = {8'h00, ioctl_dout};
          lat_vld_d = 1'b0;
        end else begin
          lat_vld_d  = 1'b1;
          lat_byte_d = ioctl_dout;
          lat_idx_d  = idx;
          lat_addr_d = waddr;
        end
      end else if (fin) begin
        a_vld     = lat_vld_q;
        lat_vld_d = 1'b0;
      end
      if (start) lat_vld_d = 1'b0;

      // One pending slot: hps_io spaces byte strobes by several clocks.
      pnd_vld_d  = 1'b0;
      pnd_idx_d  = pnd_idx_q;
      pnd_addr_d = pnd_addr_q;
      pnd_data_d = pnd_data_q;
      out_vld    = 1'b1;
      out_idx    = pnd_idx_q;
      out_addr   = pnd_addr_q;
      out_data   = pnd_data_q;
      if (pnd_vld_q) begin
        if (a_vld || b_vld) begin
          pnd_vld_d  = 1'b1;
          pnd_idx_d  = a_vld ? lat_idx_q : idx;
          pnd_addr_d = a_vld ? lat_addr_q : waddr;
          pnd_data_d = a_vld ? a_data : b_data;
        end
      end else if (a_vld) begin
        out_idx  = lat_idx_q;
        out_addr = lat_addr_q;
        out_data = a_data;
        if (b_vld) begin
          pnd_vld_d  = 1'b1;
          pnd_idx_d  = idx;
          pnd_addr_d = waddr;
          pnd_data_d = b_data;
        end
      end else begin
        out_vld  = b_vld;
        out_idx  = idx;
        out_addr = waddr;
        out_data = b_data;
      end
    end

    always_ff @(posedge clk_sys) begin
      if (reset) begin
        lat_vld_q  <= 1'b0;
        lat_byte_q <= '0;
        lat_idx_q  <= '0;
        lat_addr_q <= '0;
        pnd_vld_q  <= 1'b0;
        pnd_idx_q  <= '0;
        pnd_addr_q <= '0;
        pnd_data_q <= '0;
      end else begin
        lat_vld_q  <= lat_vld_d;
        lat_byte_q <= lat_byte_d;
        lat_idx_q  <= lat_idx_d;
        lat_addr_q <= lat_addr_d;
        pnd_vld_q  <= pnd_vld_d;
        pnd_idx_q  <= pnd_idx_d;
        pnd_addr_q <= pnd_addr_d;
        pnd_data_q <= pnd_data_d;
      end
    end
  end else begin : g_pack8
    assign out_vld  = acc;
    assign out_idx  = idx;
    assign out_addr = waddr;
    assign out_data = DATA_W'(ioctl_dout);
  end

  always_comb begin
    rom_wr_d = '0;
    for (int r = 0; r < NUM_REGIONS; r++)
      rom_wr_d[r] = out_vld && (out_idx == IDX_W'(r));
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      rom_wr_q   <= '0;
      rom_addr_q <= '0;
      rom_data_q <= '0;
      dip_q      <= '0;
      bytes_q    <= '0;
      err_q      <= '0;
      lerr_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      rom_wr_q <= rom_wr_d;
      if (out_vld) begin
        rom_addr_q <= out_addr;
        rom_data_q <= out_data;
      end
      dip_q   <= dip_d;
      bytes_q <= bytes_d;
      err_q   <= err_d;
      lerr_q  <= lerr_d;
      done_q  <= done_d;
    end
  end

  assign rom_wr       = rom_wr_q;
  assign rom_addr     = rom_addr_q;
  assign rom_data     = rom_data_q;
  assign dip_sw       = dip_q;
  assign load_done    = done_q;
  assign load_err     = lerr_q;
  assign err_code     = err_q;
  assign bytes_loaded = bytes_q;
endmodule

// File: tb/tb_rom_dl_router.sv
// Bench for rom_dl_router: byte-wide and 16-bit instances share one ioctl stream
// over a scaled-down region map with two odd-length regions.
module tb_rom_dl_router;
  localparam int               NR  = 8;
  localparam logic [24:0]      TOT = 25'h732;
  localparam logic [16*25-1:0] RB  = {{8{25'h0}}, 25'h730, 25'h720, 25'h711, 25'h700,
                                      25'h400, 25'h280, 25'h200, 25'h000};

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1, dl = 1'b0, wr = 1'b0;
  logic [24:0] addr = '0;
  logic [7:0]  dout = '0, index = '0;
  logic [7:0]  w8, w16, d8;
  logic [16:0] a8, a16;
  logic [15:0] d16, dip8, dip16;
  logic        done8, done16, lerr8, lerr16;
  logic [1:0]  ec8, ec16;
  logic [24:0] bl8, bl16;

  always #5 clk_sys = ~clk_sys;

  rom_dl_router #(.NUM_REGIONS(NR), .ADDR_W(17), .DATA_W(8), .REGION_BASE(RB),
                  .TOTAL_SIZE(TOT), .ROM_INDEX(8'd0), .DIP_INDEX(8'd254), .DIP_BYTES(2)) u8 (
    .clk_sys(clk_sys), .reset(reset), .ioctl_download(dl), .ioctl_wr(wr),
    .ioctl_addr(addr), .ioctl_dout(dout), .ioctl_index(index),
    .rom_wr(w8), .rom_addr(a8), .rom_data(d8), .dip_sw(dip8), .load_done(done8),
    .load_err(lerr8), .err_code(ec8), .bytes_loaded(bl8));

  rom_dl_router #(.NUM_REGIONS(NR), .ADDR_W(17), .DATA_W(16), .REGION_BASE(RB),
                  .TOTAL_SIZE(TOT), .ROM_INDEX(8'd0), .DIP_INDEX(8'd254), .DIP_BYTES(2)) u16 (
    .clk_sys(clk_sys), .reset(reset), .ioctl_download(dl), .ioctl_wr(wr),
    .ioctl_addr(addr), .ioctl_dout(dout), .ioctl_index(index),
    .rom_wr(w16), .rom_addr(a16), .rom_data(d16), .dip_sw(dip16), .load_done(done16),
    .load_err(lerr16), .err_code(ec16), .bytes_loaded(bl16));

  int checks = 0, errors = 0;
  int bad8, bad16, cnt16;
  bit mon16 = 1'b0;
  logic [24:0] mon_last;

  typedef struct {
    logic [24:0] a;  logic [7:0] d;
    logic [7:0]  w8; logic [16:0] a8;  logic [7:0]  d8;
    logic [7:0] w16; logic [16:0] a16; logic [15:0] d16;
  } vec_t;
  vec_t tv [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [24:0] base_of(input int r);
    return RB[r*25 +: 25];
  endfunction
  function automatic logic [24:0] end_of(input int r);
    return (r == NR-1) ? TOT : RB[(r+1)*25 +: 25];
  endfunction
  function automatic logic [7:0] pat(input logic [24:0] a);
    return a[7:0] ^ {a[10:8], 5'b10110};
  endfunction
  function automatic int region_of(input logic [24:0] a);
    int r;
    r = -1;
    for (int i = 0; i < NR; i++) if (a >= base_of(i) && a < TOT) r = i;
    return r;
  endfunction
  function automatic int exp_words(input int hi);
    int n, t;
    t = 0;
    for (int r = 0; r < NR; r++) begin
      n = ((int'(end_of(r)) < hi + 1) ? int'(end_of(r)) : hi + 1) - int'(base_of(r));
      if (n > 0) t += (n + 1) / 2;
    end
    return t;
  endfunction

  // Every 16-bit word emitted during a stream must hold the bytes of its region.
  always @(negedge clk_sys) begin
    int r;
    logic [24:0] lo, hi;
    logic [15:0] e;
    if (mon16 && w16 != 8'h00) begin
      cnt16++;
      r = -1;
      for (int i = 0; i < NR; i++) if (w16 == 8'(1 << i)) r = i;
      if (r < 0) bad16++;
      else begin
        lo = base_of(r) + 25'({a16, 1'b0});
        hi = lo + 25'd1;
        e  = {(hi < end_of(r) && hi <= mon_last) ? pat(hi) : 8'h00, pat(lo)};
        if (lo >= end_of(r) || d16 !== e) bad16++;
      end
    end
  end

  task automatic put(input logic [7:0] ix, input logic [24:0] a, input logic [7:0] d);
    @(negedge clk_sys);
    index = ix; wr = 1'b1; addr = a; dout = d;
    @(negedge clk_sys);
    wr = 1'b0;
  endtask

  task automatic begin_dl();
    @(negedge clk_sys);
    dl = 1'b1; index = 8'd0;
    @(negedge clk_sys);
  endtask

  task automatic end_dl();
    @(negedge clk_sys);
    dl = 1'b0;
    repeat (2) @(negedge clk_sys);
  endtask

  task automatic stream(input int lo, input int hi);
    int r;
    for (int a = lo; a <= hi; a++) begin
      put(8'd0, 25'(a), pat(25'(a)));
      r = region_of(25'(a));
      if (r < 0) begin
        if (w8 !== 8'h00) bad8++;
      end else if (w8 !== 8'(1 << r) || a8 !== 17'(a - int'(base_of(r))) || d8 !== pat(25'(a)))
        bad8++;
    end
  endtask

  task automatic run_stream(input int hi, input bit extra);
    bad8 = 0; bad16 = 0; cnt16 = 0; mon_last = 25'(hi); mon16 = 1'b1;
    begin_dl();
    stream(0, hi);
    if (extra) stream(int'(TOT), int'(TOT));
    end_dl();
    mon16 = 1'b0;
    chk("stream8_bad", bad8, 0);
    chk("stream16_bad", bad16, 0);
    chk("stream16_cnt", cnt16, exp_words(hi));
  endtask

  task automatic status(input string t, input logic dn, input logic le, input logic [1:0] ec,
                        input logic [24:0] bl);
    chk({t, "_done8"}, done8, dn);   chk({t, "_done16"}, done16, dn);
    chk({t, "_lerr8"}, lerr8, le);   chk({t, "_lerr16"}, lerr16, le);
    chk({t, "_ec8"}, ec8, ec);       chk({t, "_ec16"}, ec16, ec);
    chk({t, "_bytes8"}, bl8, bl);    chk({t, "_bytes16"}, bl16, bl);
  endtask

  task automatic zeros(input string t);
    chk({t, "_w8"}, w8, 0);      chk({t, "_w16"}, w16, 0);
    chk({t, "_a8"}, a8, 0);      chk({t, "_a16"}, a16, 0);
    chk({t, "_d8"}, d8, 0);      chk({t, "_d16"}, d16, 0);
    chk({t, "_dip8"}, dip8, 0);  chk({t, "_dip16"}, dip16, 0);
    status(t, 1'b0, 1'b0, 2'd0, 25'd0);
  endtask

  initial begin
    int q;
    tv[0]  = '{25'h000, 8'h34, 8'h01, 17'h000, 8'h34, 8'h00, 17'h000, 16'h0000};
    tv[1]  = '{25'h001, 8'h12, 8'h01, 17'h001, 8'h12, 8'h01, 17'h000, 16'h1234};
    tv[2]  = '{25'h200, 8'hAA, 8'h02, 17'h000, 8'hAA, 8'h00, 17'h000, 16'h0000};
    tv[3]  = '{25'h201, 8'h55, 8'h02, 17'h001, 8'h55, 8'h02, 17'h000, 16'h55AA};
    tv[4]  = '{25'h711, 8'h77, 8'h20, 17'h000, 8'h77, 8'h00, 17'h000, 16'h0000};
    tv[5]  = '{25'h712, 8'h66, 8'h20, 17'h001, 8'h66, 8'h20, 17'h000, 16'h6677};
    tv[6]  = '{25'h716, 8'h99, 8'h20, 17'h005, 8'h99, 8'h20, 17'h002, 16'h9900};
    tv[7]  = '{25'h6FF, 8'h42, 8'h08, 17'h2FF, 8'h42, 8'h08, 17'h17F, 16'h4200};
    tv[8]  = '{25'h732, 8'hEE, 8'h00, 17'h000, 8'h00, 8'h00, 17'h000, 16'h0000};
    tv[9]  = '{25'h1FFFFFF, 8'h01, 8'h00, 17'h000, 8'h00, 8'h00, 17'h000, 16'h0000};
    tv[10] = '{25'h730, 8'h5A, 8'h80, 17'h000, 8'h5A, 8'h00, 17'h000, 16'h0000};

    repeat (2) @(negedge clk_sys);
    zeros("reset");
    reset = 1'b0;

    // Short load, then a complete load clears the error, then an overflow byte.
    run_stream(int'(TOT) - 2, 1'b0);
    status("short", 1'b0, 1'b1, 2'd1, TOT - 25'd1);
    run_stream(int'(TOT) - 1, 1'b0);
    status("full", 1'b1, 1'b0, 2'd0, TOT);
    run_stream(int'(TOT) - 1, 1'b1);
    status("ovf", 1'b0, 1'b1, 2'd2, TOT);

    begin_dl();
    foreach (tv[i]) begin
      put(8'd0, tv[i].a, tv[i].d);
      chk($sformatf("v%0d_w8", i), w8, tv[i].w8);
      chk($sformatf("v%0d_w16", i), w16, tv[i].w16);
      if (tv[i].w8 != 8'h00) begin
        chk($sformatf("v%0d_a8", i), a8, tv[i].a8);
        chk($sformatf("v%0d_d8", i), d8, tv[i].d8);
      end
      if (tv[i].w16 != 8'h00) begin
        chk($sformatf("v%0d_a16", i), a16, tv[i].a16);
        chk($sformatf("v%0d_d16", i), d16, tv[i].d16);
      end
    end
    // Latched even byte of region 7 is flushed as the load ends.
    @(negedge clk_sys);
    dl = 1'b0;
    @(negedge clk_sys);
    chk("flush_w8", w8, 8'h00);
    chk("flush_w16", w16, 8'h80);
    chk("flush_a16", a16, 17'h0);
    chk("flush_d16", d16, 16'h005A);
    @(negedge clk_sys);
    chk("after_flush_w16", w16, 8'h00);
    status("vec", 1'b0, 1'b1, 2'd3, 25'd9);

    @(negedge clk_sys);
    dl = 1'b1; index = 8'd254;
    q = 0;
    put(8'd254, 25'd0, 8'hA5); q += (w8 != 0) + (w16 != 0);
    put(8'd254, 25'd1, 8'h3C); q += (w8 != 0) + (w16 != 0);
    put(8'd254, 25'd2, 8'hFF); q += (w8 != 0) + (w16 != 0);
    dl = 1'b0;
    @(negedge clk_sys);
    chk("dip_romwr", q, 0);
    chk("dip8", dip8, 16'h3CA5);
    chk("dip16", dip16, 16'h3CA5);
    status("dip", 1'b0, 1'b1, 2'd3, 25'd9);

    // Reset with an even byte latched in the 16-bit instance: no flush afterwards.
    bad8 = 0;
    begin_dl();
    stream(32'h4F0, 32'h500);
    chk("pre_reset_bad8", bad8, 0);
    @(negedge clk_sys);
    reset = 1'b1; dl = 1'b0;
    @(negedge clk_sys);
    reset = 1'b0;
    zeros("midrst");
    q = 0;
    repeat (3) begin
      @(negedge clk_sys);
      q += (w8 != 0) + (w16 != 0);
    end
    chk("post_reset_romwr", q, 0);
    status("post_reset", 1'b0, 1'b0, 2'd0, 25'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rom_dl_router.md
Name: rom_dl_router

Overview:
- Parametrised successor to the fixed single-index ROM download hookup in the arcade top level.
- Routes the HPS ioctl byte stream into NUM_REGIONS ROM/PROM regions. Each region has its own write strobe and a region-relative address.
- Packs bytes into DATA_W-wide words, captures DIP bytes from a second ioctl index, and tracks load completion, short loads and overflow.
- Sits between hps_io and the game core, in the clk_sys domain.

Parameters:
- NUM_REGIONS, 8: number of ROM regions; range 1..16.
- ADDR_W, 17: width of the region-relative byte address.
- DATA_W, 8: output word width; legal values are 8 and 16.
- REGION_BASE, {16{25'h0}}: packed 16x25-bit array of absolute start addresses. Entries 0..NUM_REGIONS-1 are used and must ascend strictly.
- TOTAL_SIZE, 25'h1C320: end of the image, exclusive. Bytes at or above it are overflow. Region i ends at REGION_BASE[i+1], and the last region ends at TOTAL_SIZE.
- ROM_INDEX, 0: ioctl_index value for the ROM image.
- DIP_INDEX, 254: ioctl_index value for the DIP download.
- DIP_BYTES, 2: number of DIP bytes captured.

Ports:
- clk_sys, in, 1: the single clock.
- reset, in, 1: synchronous, active-high reset. All registers take their reset value on the clock edge where reset=1.
- ioctl_download, in, 1: download active.
- ioctl_wr, in, 1: byte strobe, one cycle per byte.
- ioctl_addr, in, 25: absolute byte address.
- ioctl_dout, in, 8: byte data.
- ioctl_index, in, 8: download index.
- rom_wr, out, NUM_REGIONS: one-hot write strobe per region.
- rom_addr, out, ADDR_W: region-relative word address, equal to the byte offset >> log2(DATA_W/8).
- rom_data, out, DATA_W: word data.
- dip_sw, out, 8*DIP_BYTES: captured DIP bytes; byte k sits at bits [8k+7:8k].
- load_done, out, 1: a ROM image loaded completely.
- load_err, out, 1: sticky error, cleared by a new ROM download.
- err_code, out, 2: 0 = none, 1 = short load, 2 = overflow, 3 = both.
- bytes_loaded, out, 25: count of accepted in-range ROM bytes.

Behaviour:
- Reset values: rom_wr=0, rom_addr=0, rom_data=0, dip_sw=0, load_done=0, load_err=0, err_code=0, bytes_loaded=0, state=IDLE, pack latch empty.
- The FSM has three states: IDLE, LOAD, DONE.
  - IDLE -> LOAD on ioctl_download=1 with ioctl_index==ROM_INDEX. On entry: clear bytes_loaded, err_code, load_err and load_done; empty the pack latch.
  - LOAD -> DONE on ioctl_download=0.
    - If bytes_loaded < TOTAL_SIZE, set err_code bit0 and load_err.
    - load_done=1 only if err_code==0 after this update.
  - DONE -> LOAD on a new ROM download, with the same clears as IDLE -> LOAD.
- DIP capture: on ioctl_wr with ioctl_index==DIP_INDEX and ioctl_addr < DIP_BYTES, write dip_sw byte[addr].
  - DIP capture works in any FSM state.
  - It does not touch the ROM state, bytes_loaded or the error flags.
- Region decode, combinational on ioctl_addr: select the highest i with REGION_BASE[i] <= addr; offset = addr - REGION_BASE[i].
  - addr >= TOTAL_SIZE, or addr below REGION_BASE[0]: no strobe, set err_code bit1 and load_err.
  - Offset bits above ADDR_W are truncated. Configuration must guarantee that every region fits within 2^ADDR_W.
- Writes with DATA_W=8:
  - ioctl_wr in LOAD with a valid region registers rom_wr[i]=1, rom_addr=offset and rom_data=byte.
  - Latency is 1 cycle from ioctl_wr to rom_wr; the strobe is 1 cycle wide.
- Writes with DATA_W=16 (little-endian):
  - Even offset: latch the low byte; no strobe.
  - Odd offset: emit rom_wr[i] with rom_data={byte, latched_low} and rom_addr=offset>>1.
  - Latency is 1 cycle from the odd byte.
  - A region ending on an odd byte count: the final even byte is flushed on region change or on LOAD->DONE with its high byte = 8'h00. This costs 1 extra strobe cycle. Both cases are legal.
  - An odd byte arriving without its preceding even byte (skipped address): write using latch value 0.
- bytes_loaded increments by 1 per accepted in-range ROM byte and saturates at 2^25-1.
- ioctl_wr outside LOAD with ROM_INDEX: ignored.
- Reset during LOAD: returns to IDLE next edge, outputs at reset values, and no partial word is flushed.
- ioctl_wr and the LOAD->DONE transition in the same cycle: the byte is processed first and included in the length check.

Decomposition:
- Package rom_dl_pkg holds:
  - the state enum (IDLE, LOAD, DONE);
  - ERR_SHORT=2'b01 and ERR_OVF=2'b10;
  - the clog2-based helper function for the word shift.
- Sub-module rom_region_decode: combinational, takes the address and returns hit, index and offset, parametrised by NUM_REGIONS, REGION_BASE and TOTAL_SIZE.

Test Plan:
1. Defaults with bases 0,8000,A000,10000,1C000,1C100,1C200,1C300; stream 0..1C31F -> each region strobed only in its range; byte at 1C000 gives rom_wr[4], rom_addr=0; load_done=1, err_code=0, bytes_loaded=1C320.
2. DATA_W=16; bytes 0x34 at addr 0, then 0x12 at addr 1 -> a single rom_wr[0] 1 cycle after the second byte, rom_addr=0, rom_data=16'h1234.
3. Download stops at 1C31E -> load_done=0, load_err=1, err_code=1; a following complete download clears err_code and sets load_done=1.
4. Extra byte at 1C320 -> no rom_wr, err_code bit1 set; all in-range writes are still issued.
5. DIP_INDEX download of 8'hA5, 8'h3C -> dip_sw=16'h3CA5; rom_wr stays 0 and bytes_loaded is unchanged.
6. reset asserted mid-LOAD at addr 9000 -> next cycle state IDLE and all outputs at reset values; with DATA_W=16 and an even byte latched, no flush strobe is emitted.
